acia_rx_shifter: RTL

ACIA_RX_SHIFTER -- requirements
Module: acia_rx_shifter

---
 rtl/acia_rx_shifter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/acia_rx_shifter.sv
// rtl/acia_rx_shifter.sv - ACIA receive shifter: oversampled serial-to-parallel with parity/framing/overrun status
//
// Ports:
//   XTLI     system clock, all state on its rising edge
//   RESET    synchronous active-high reset
//   BCLK_EN  one-cycle strobe at OVERSAMPLE x baud rate
//   RXD      asynchronous serial input, idle high
//   R_WL     word length (00=8, 01=7, 10=6, 11=5 data bits)
//   R_PEN    parity bit present
//   R_PMC    parity mode (00=odd, 01=even, 10=mark, 11=space)
//   RD_ACK   one-cycle pulse: CPU has read RDR
//   RDR      received data register (unused upper bits zero)
//   RDRF     receive data register full
//   PE/FE    parity / framing error of the character held in RDR
//   OVR      a character was dropped because RDR was still full
module acia_rx_shifter #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       XTLI,
    input  logic       RESET,
    input  logic       BCLK_EN,
    input  logic       RXD,
    input  logic [1:0] R_WL,
    input  logic       R_PEN,
    input  logic [1:0] R_PMC,
    input  logic       RD_ACK,
    output logic [7:0] RDR,
    output logic       RDRF,
    output logic       PE,
    output logic       FE,
    output logic       OVR
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            rxd_meta_q, rxd_meta_d;
    logic            rxd_sync_q, rxd_sync_d;
    // Synchronized line value seen on the previous BCLK_EN tick; a start
    // needs this high, so a held-low break cannot retrigger.
    logic            rxd_last_q, rxd_last_d;
    logic [1:0]      wl_q, wl_d;
    logic            pen_q, pen_d;
    logic [1:0]      pmc_q, pmc_d;
    logic            pe_pend_q, pe_pend_d;
    logic [7:0]      rdr_q, rdr_d;
    logic            rdrf_q, rdrf_d;
    logic            pe_q, pe_d;
    logic            fe_q, fe_d;
    logic            ovr_q, ovr_d;

    logic            stop_sample;
    logic            par_exp;
    logic [2:0]      last_bit;

    // Index of the final data bit for the latched word length (7 down to 4).
    assign last_bit = 3'd7 - {1'b0, wl_q};

    // Expected parity bit; shreg is zero-filled so reduction covers data only.
    always_comb begin
        par_exp = 1'b0;
        case (pmc_q)
            2'b00:   par_exp = ~^shreg_q;
            2'b01:   par_exp = ^shreg_q;
            2'b10:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        rxd_meta_d  = RXD;
        rxd_sync_d  = rxd_meta_q;
        rxd_last_d  = rxd_last_q;
        wl_d        = wl_q;
        pen_d       = pen_q;
        pmc_d       = pmc_q;
        pe_pend_d   = pe_pend_q;
        rdr_d       = rdr_q;
        rdrf_d      = rdrf_q;
        pe_d        = pe_q;
        fe_d        = fe_q;
        ovr_d       = ovr_q;
        stop_sample = 1'b0;

        if (BCLK_EN) begin
            rxd_last_d = rxd_sync_q;
            case (state_q)
                S_IDLE: begin
                    if (rxd_last_q && !rxd_sync_q) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    if (tick_q == HALF_M1) begin
                        tick_d = '0;
                        if (!rxd_sync_q) begin
                            // Frame format is frozen here for the whole character.
                            state_d   = S_DATA;
                            bit_d     = 3'd0;
                            shreg_d   = 8'h00;
                            wl_d      = R_WL;
                            pen_d     = R_PEN;
                            pmc_d     = R_PMC;
                            pe_pend_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                S_DATA: begin
                    if (tick_q == FULL_M1) begin
                        tick_d          = '0;
                        shreg_d[bit_q]  = rxd_sync_q;
                        if (bit_q == last_bit) begin
                            bit_d   = 3'd0;
                            state_d = pen_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                S_PARITY: begin
                    if (tick_q == FULL_M1) begin
                        tick_d    = '0;
                        pe_pend_d = (rxd_sync_q != par_exp);
                        state_d   = S_STOP;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                S_STOP: begin
                    if (tick_q == FULL_M1) begin
                        tick_d      = '0;
                        stop_sample = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end

        // A read in the same cycle as the stop sample frees RDR for the new
        // character, so that case loads rather than overruns.
        if (stop_sample) begin
            if (!rdrf_q || RD_ACK) begin
                rdr_d  = shreg_q;
                rdrf_d = 1'b1;
                pe_d   = pe_pend_q;
                fe_d   = !rxd_sync_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (RD_ACK) begin
            rdrf_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge XTLI) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'h00;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_last_q <= 1'b1;
            wl_q       <= 2'b00;
            pen_q      <= 1'b0;
            pmc_q      <= 2'b00;
            pe_pend_q  <= 1'b0;
            rdr_q      <= 8'h00;
            rdrf_q     <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            rxd_meta_q <= rxd_meta_d;
            rxd_sync_q <= rxd_sync_d;
            rxd_last_q <= rxd_last_d;
            wl_q       <= wl_d;
            pen_q      <= pen_d;
            pmc_q      <= pmc_d;
            pe_pend_q  <= pe_pend_d;
            rdr_q      <= rdr_d;
            rdrf_q     <= rdrf_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
        end
    end

    assign RDR  = rdr_q;
    assign RDRF = rdrf_q;
    assign PE   = pe_q;
    assign FE   = fe_q;
    assign OVR  = ovr_q;

endmodule
